// File: rtl/mips_pkg.sv
// mips_pkg: loader state encoding and stream framing constants shared by the imem loader.
// The CHK state only exists when IMEM_LOADER_CHECKSUM_EN is defined.
package mips_pkg;
    localparam int WORD_BYTES = 4;
    localparam int LEN_BYTES = 2;
    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        WORD,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK,
`endif
        DONE,
        ERR
    } ld_state_t;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: UART byte input, reload request, instruction-memory write port and core control.
interface imem_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        reload;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_rst_n;
    logic        done;
    logic        err;
    modport master (input rx_data, rx_valid, reload, output wr_en, wr_addr, wr_data, cpu_rst_n, done, err);
    modport slave (output rx_data, rx_valid, reload, input wr_en, wr_addr, wr_data, cpu_rst_n, done, err);
endinterface

// File: rtl/imem_loader_word_packer.sv
// word_packer: shifts in bytes MSB first and strobes ready with the assembled word on the 4th byte.
module word_packer
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        ready
);
    logic [23:0] sr;
    logic [1:0]  cnt;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (clr) begin
            sr  <= '0;
            cnt <= '0;
        end else if (byte_valid) begin
            sr  <= {sr[15:0], byte_in};
            cnt <= cnt + 2'd1;
        end
    // Word is combined with the live byte so the strobe lands on the 4th byte's cycle.
    assign word  = {sr, byte_in};
    assign ready = byte_valid && cnt == 2'(WORD_BYTES - 1);
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed UART program into instruction memory, holding the core in reset until done.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
    import mips_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic clk,
    input logic rst,
    imem_loader_if.master bus
);
    ld_state_t   state, nxt;
    logic [15:0] n, n_cur, wcnt;
    logic [31:0] word;
    logic        ready, pack_en, clr;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam ld_state_t FIN = CHK;
    logic [7:0] xsum;
`else
    localparam ld_state_t FIN = DONE;
`endif
    assign n_cur = {n[15:8], bus.rx_data};

    word_packer u_pack (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .byte_valid (pack_en),
        .byte_in    (bus.rx_data),
        .word       (word),
        .ready      (ready)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= LEN_HI;
        else state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            LEN_HI: nxt = bus.rx_valid ? LEN_LO : LEN_HI;
            LEN_LO: if (bus.rx_valid) nxt = 32'(n_cur) > MAX_WORDS ? ERR : n_cur == '0 ? FIN : WORD;
            WORD:   if (ready && wcnt + 16'd1 == n) nxt = FIN;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK:    if (bus.rx_valid) nxt = bus.rx_data == xsum ? DONE : ERR;
`endif
            DONE, ERR: if (bus.reload) nxt = LEN_HI;
            default: nxt = LEN_HI;
        endcase
    end

    always_comb begin
        pack_en = bus.rx_valid && state == WORD;
        clr     = bus.reload && (state == DONE || state == ERR);
    end

    // done/cpu_rst_n rise one cycle after entering DONE so they never coincide with the last wr_en.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            n             <= '0;
            wcnt          <= '0;
            bus.wr_en     <= 1'b0;
            bus.wr_addr   <= BASE_ADDR;
            bus.wr_data   <= '0;
            bus.done      <= 1'b0;
            bus.cpu_rst_n <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            bus.wr_en     <= ready;
            bus.done      <= state == DONE && nxt == DONE;
            bus.cpu_rst_n <= state == DONE && nxt == DONE;
            bus.err       <= nxt == ERR;
            if (bus.rx_valid && state == LEN_HI) n[15:8] <= bus.rx_data;
            if (bus.rx_valid && state == LEN_LO) n <= n_cur;
            if (ready) begin
                bus.wr_addr <= BASE_ADDR + {14'd0, wcnt, 2'b00};
                bus.wr_data <= word;
                wcnt        <= wcnt + 16'd1;
            end
            if (clr) wcnt <= '0;
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst)
        if (!rst) xsum <= '0;
        else if (clr) xsum <= '0;
        else if (bus.rx_valid && (state == LEN_HI || state == LEN_LO || state == WORD)) xsum <= xsum ^ bus.rx_data;
`endif
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed-stream bench for the UART instruction-memory loader.
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;
    int nw = 0;
    logic [31:0] la [8];
    logic [31:0] ld [8];

    imem_loader_if bus ();
    imem_loader dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Logs every write pulse and flags any overlap with done.
    always @(negedge clk)
        if (bus.wr_en === 1'b1) begin
            checks++;
            if (bus.done !== 1'b0) begin
                failures++;
                $display("FAIL wr_done_overlap done=%b exp=0", bus.done);
            end
            if (nw < 8) begin
                la[nw] = bus.wr_addr;
                ld[nw] = bus.wr_data;
            end
            nw++;
        end

    task send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task send_tail(input logic [7:0] x);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(x);
`else
        bus.rx_data = x;
`endif
    endtask

    task pulse_reload;
        @(negedge clk);
        bus.reload = 1'b1;
        @(negedge clk);
        bus.reload = 1'b0;
    endtask

    task test_reset;
        bus.rx_data = 8'h00;
        bus.rx_valid = 1'b0;
        bus.reload = 1'b0;
        rst = 1'b0;
        #12;
        checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en got=%b exp=0", bus.wr_en); end
        checks++; if (bus.wr_addr !== 32'h0) begin failures++; $display("FAIL rst_wr_addr got=%h exp=0", bus.wr_addr); end
        checks++; if (bus.wr_data !== 32'h0) begin failures++; $display("FAIL rst_wr_data got=%h exp=0", bus.wr_data); end
        checks++; if (bus.cpu_rst_n !== 1'b0) begin failures++; $display("FAIL rst_cpu_rst_n got=%b exp=0", bus.cpu_rst_n); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", bus.done); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", bus.err); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task test_two_words;
        nw = 0;
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
        send_byte(8'hAC); send_byte(8'h08); send_byte(8'h00); send_byte(8'h00);
        checks++; if (bus.wr_en !== 1'b1) begin failures++; $display("FAIL two_last_wr_en got=%b exp=1", bus.wr_en); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL two_early_done got=%b exp=0", bus.done); end
        send_tail(8'h8B);
        @(negedge clk);
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL two_done got=%b exp=1", bus.done); end
        checks++; if (bus.cpu_rst_n !== 1'b1) begin failures++; $display("FAIL two_cpu_rst_n got=%b exp=1", bus.cpu_rst_n); end
        checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL two_wr_en_width got=%b exp=0", bus.wr_en); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL two_err got=%b exp=0", bus.err); end
        #1;
        checks++; if (nw !== 2) begin failures++; $display("FAIL two_count got=%0d exp=2", nw); end
        checks++; if (la[0] !== 32'h0) begin failures++; $display("FAIL two_addr0 got=%h exp=00000000", la[0]); end
        checks++; if (ld[0] !== 32'h2008_0005) begin failures++; $display("FAIL two_data0 got=%h exp=20080005", ld[0]); end
        checks++; if (la[1] !== 32'h4) begin failures++; $display("FAIL two_addr1 got=%h exp=00000004", la[1]); end
        checks++; if (ld[1] !== 32'hAC08_0000) begin failures++; $display("FAIL two_data1 got=%h exp=ac080000", ld[1]); end
        checks++; if (bus.wr_addr !== 32'h4) begin failures++; $display("FAIL two_addr_hold got=%h exp=00000004", bus.wr_addr); end
        checks++; if (bus.wr_data !== 32'hAC08_0000) begin failures++; $display("FAIL two_data_hold got=%h exp=ac080000", bus.wr_data); end
    endtask

    task test_reload;
        pulse_reload;
        checks++; if (bus.cpu_rst_n !== 1'b0) begin failures++; $display("FAIL reload_cpu_rst_n got=%b exp=0", bus.cpu_rst_n); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reload_done got=%b exp=0", bus.done); end
        nw = 0;
        send_byte(8'h00); send_byte(8'h01);
        pulse_reload;
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_tail(8'h45);
        @(negedge clk);
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL reload_done2 got=%b exp=1", bus.done); end
        #1;
        checks++; if (nw !== 1) begin failures++; $display("FAIL reload_count got=%0d exp=1", nw); end
        checks++; if (la[0] !== 32'h0) begin failures++; $display("FAIL reload_addr got=%h exp=00000000", la[0]); end
        checks++; if (ld[0] !== 32'h1122_3344) begin failures++; $display("FAIL reload_data got=%h exp=11223344", ld[0]); end
    endtask

    task test_zero;
        pulse_reload;
        nw = 0;
        send_byte(8'h00); send_byte(8'h00);
        send_tail(8'h00);
        @(negedge clk);
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", bus.done); end
        checks++; if (bus.cpu_rst_n !== 1'b1) begin failures++; $display("FAIL zero_cpu_rst_n got=%b exp=1", bus.cpu_rst_n); end
        #1;
        checks++; if (nw !== 0) begin failures++; $display("FAIL zero_count got=%0d exp=0", nw); end
    endtask

    task test_too_big;
        pulse_reload;
        nw = 0;
        send_byte(8'h01); send_byte(8'h01);
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL big_err got=%b exp=1", bus.err); end
        checks++; if (bus.cpu_rst_n !== 1'b0) begin failures++; $display("FAIL big_cpu_rst_n got=%b exp=0", bus.cpu_rst_n); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL big_done got=%b exp=0", bus.done); end
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44); send_byte(8'h55);
        #1;
        checks++; if (nw !== 0) begin failures++; $display("FAIL big_count got=%0d exp=0", nw); end
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL big_err_hold got=%b exp=1", bus.err); end
        checks++; if (bus.cpu_rst_n !== 1'b0) begin failures++; $display("FAIL big_cpu_hold got=%b exp=0", bus.cpu_rst_n); end
    endtask

    task test_reset_mid;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL mid_err_clear got=%b exp=0", bus.err); end
        nw = 0;
        send_byte(8'h00); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
        @(negedge clk); rst = 1'b0;
        #1;
        checks++; if (bus.cpu_rst_n !== 1'b0) begin failures++; $display("FAIL mid_cpu_rst_n got=%b exp=0", bus.cpu_rst_n); end
        checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL mid_wr_en got=%b exp=0", bus.wr_en); end
        @(negedge clk); rst = 1'b1;
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hCA); send_byte(8'hFE); send_byte(8'hBA); send_byte(8'hBE);
        send_tail(8'h31);
        @(negedge clk);
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL mid_done got=%b exp=1", bus.done); end
        #1;
        checks++; if (nw !== 1) begin failures++; $display("FAIL mid_count got=%0d exp=1", nw); end
        checks++; if (la[0] !== 32'h0) begin failures++; $display("FAIL mid_addr got=%h exp=00000000", la[0]); end
        checks++; if (ld[0] !== 32'hCAFE_BABE) begin failures++; $display("FAIL mid_data got=%h exp=cafebabe", ld[0]); end
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    task test_checksum;
        pulse_reload;
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        send_byte(8'h09);
        @(negedge clk);
        checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL chk_good_done got=%b exp=1", bus.done); end
        pulse_reload;
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        send_byte(8'h00);
        checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL chk_bad_err got=%b exp=1", bus.err); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL chk_bad_done got=%b exp=0", bus.done); end
    endtask
`endif

    initial begin
        test_reset;
        test_two_words;
        test_reload;
        test_zero;
        test_too_big;
        test_reset_mid;
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
